// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide sequencer.
// Optional build macro used by the sequencer: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

  localparam int XLEN = 32;

  // Fixed quotient for divide-by-zero and the most negative signed value.
  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
  localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

  // RV32M funct3 encodings.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Returns {aluop1_signed, aluop2_signed} for an operation.
  function automatic logic [1:0] is_signed_op(input op_t op);
    logic [1:0] sgn;
    sgn = 2'b00;
    case (op)
      OP_MULH, OP_DIV, OP_REM: sgn = 2'b11;
      OP_MULHSU:               sgn = 2'b10;
      default:                 sgn = 2'b00;
    endcase
    return sgn;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iteration register pair {hi, lo} plus the shared adder/subtractor.
// Multiply: {hi, lo} is the product register, lo starts as the multiplier and
// the stored operand is the multiplicand (shift-add, LSB first).
// Divide: hi is the partial remainder, lo the dividend/quotient, the stored
// operand is the divisor (restoring division, MSB first).
module muldiv_iter import muldiv_pkg::*; #(
  parameter int D_WIDTH = XLEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_en,
  input  logic               i_div,
  input  logic [D_WIDTH-1:0] i_opa,
  input  logic [D_WIDTH-1:0] i_opb,
  output logic [D_WIDTH-1:0] o_hi,
  output logic [D_WIDTH-1:0] o_lo
);

  logic [D_WIDTH-1:0] r_hi;
  logic [D_WIDTH-1:0] r_lo;
  logic [D_WIDTH-1:0] r_opb;

  // Two extra bits: one for the shifted-in remainder bit, one for the borrow.
  logic [D_WIDTH+1:0] w_a;
  logic [D_WIDTH+1:0] w_b;
  logic [D_WIDTH+1:0] w_sum;
  logic               w_cin;

  // Shared adder: hi + operand for multiply, {hi, lo MSB} - operand for divide.
  always_comb begin
    w_a   = {2'b00, r_hi};
    w_b   = {2'b00, r_opb};
    w_cin = 1'b0;
    if (i_div) begin
      w_a   = {1'b0, r_hi, r_lo[D_WIDTH-1]};
      w_b   = ~{2'b00, r_opb};
      w_cin = 1'b1;
    end
    w_sum = w_a + w_b + {{(D_WIDTH+1){1'b0}}, w_cin};
  end

  // Iteration registers: load operands on accept, one step per enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_opb <= '0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_opa;
      r_opb <= i_opb;
    end else if (i_en) begin
      if (i_div) begin
        if (!w_sum[D_WIDTH+1]) begin
          r_hi <= w_sum[D_WIDTH-1:0];
          r_lo <= {r_lo[D_WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= {r_hi[D_WIDTH-2:0], r_lo[D_WIDTH-1]};
          r_lo <= {r_lo[D_WIDTH-2:0], 1'b0};
        end
      end else begin
        if (r_lo[0]) begin
          r_hi <= w_sum[D_WIDTH:1];
          r_lo <= {w_sum[0], r_lo[D_WIDTH-1:1]};
        end else begin
          r_hi <= {1'b0, r_hi[D_WIDTH-1:1]};
          r_lo <= {r_hi[0], r_lo[D_WIDTH-1:1]};
        end
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer (IDLE/CALC/FIXUP/DONE).
// Operands are reduced to magnitudes at accept; signs are reapplied in FIXUP.
// Build macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// multiply-by-zero skip CALC and complete with done in the cycle after accept.
module muldiv_seq import muldiv_pkg::*; #(
  parameter int D_WIDTH = XLEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [D_WIDTH-1:0] aluop1,
  input  logic [D_WIDTH-1:0] aluop2,
  input  logic               flush,
  output logic               busy,
  output logic               stall,
  output logic               done,
  output logic [D_WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(D_WIDTH);
  localparam logic [D_WIDTH-1:0] L_ONES    = D_WIDTH'(DIV_ZERO_Q);
  localparam logic [D_WIDTH-1:0] L_INT_MIN = D_WIDTH'(INT_MIN);

  state_t             r_state;
  op_t                r_op;
  logic               r_neg1;
  logic               r_neg2;
  logic               r_div0;
  logic [CNT_W-1:0]   r_cnt;
  logic [D_WIDTH-1:0] r_result;

  op_t                w_op;
  logic [1:0]         w_sgn;
  logic               w_neg1;
  logic               w_neg2;
  logic [D_WIDTH-1:0] w_mag1;
  logic [D_WIDTH-1:0] w_mag2;
  logic               w_b_zero;
  logic               w_accept;
  logic               w_iter_en;
  logic [D_WIDTH-1:0] w_hi;
  logic [D_WIDTH-1:0] w_lo;
  logic [2*D_WIDTH-1:0] w_prod;
  logic [2*D_WIDTH-1:0] w_prod_fix;
  logic [D_WIDTH-1:0] w_quo_fix;
  logic [D_WIDTH-1:0] w_rem_fix;
  logic [D_WIDTH-1:0] w_fix;

  assign w_op      = op_t'(op);
  assign w_sgn     = is_signed_op(w_op);
  assign w_neg1    = w_sgn[1] & aluop1[D_WIDTH-1];
  assign w_neg2    = w_sgn[0] & aluop2[D_WIDTH-1];
  assign w_mag1    = w_neg1 ? -aluop1 : aluop1;
  assign w_mag2    = w_neg2 ? -aluop2 : aluop2;
  assign w_b_zero  = (aluop2 == '0);
  assign w_accept  = (r_state == IDLE) & start & ~flush;
  assign w_iter_en = (r_state == CALC) & ~flush;

  muldiv_iter #(.D_WIDTH(D_WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_en   (w_iter_en),
    .i_div  (r_op[2]),
    .i_opa  (w_mag1),
    .i_opb  (w_mag2),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  // Sign fixup of the raw magnitude results and selection of the result field.
  // Signed overflow needs no override: |INT_MIN| / 1 with equal signs already
  // yields INT_MIN, remainder 0. Divide-by-zero leaves the dividend in the
  // remainder, so only the quotient is forced.
  always_comb begin
    w_prod     = {w_hi, w_lo};
    w_prod_fix = (r_neg1 ^ r_neg2) ? -w_prod : w_prod;
    w_quo_fix  = r_div0 ? L_ONES : ((r_neg1 ^ r_neg2) ? -w_lo : w_lo);
    w_rem_fix  = r_neg1 ? -w_hi : w_hi;
    case (r_op)
      OP_MUL:                       w_fix = w_prod_fix[D_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod_fix[2*D_WIDTH-1:D_WIDTH];
      OP_DIV, OP_DIVU:              w_fix = w_quo_fix;
      default:                      w_fix = w_rem_fix;
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic               w_ovf;
  logic               w_special;
  logic [D_WIDTH-1:0] w_special_val;

  assign w_ovf = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                 (aluop1 == L_INT_MIN) && (aluop2 == L_ONES);

  // Fixed results that are known at accept time.
  always_comb begin
    w_special     = 1'b0;
    w_special_val = '0;
    if (w_op[2]) begin
      if (w_b_zero) begin
        w_special     = 1'b1;
        w_special_val = w_op[1] ? aluop1 : L_ONES;
      end else if (w_ovf) begin
        w_special     = 1'b1;
        w_special_val = w_op[1] ? '0 : L_INT_MIN;
      end
    end else if ((aluop1 == '0) || w_b_zero) begin
      w_special     = 1'b1;
      w_special_val = '0;
    end
  end
`endif

  // Sequencer FSM: accept, iterate D_WIDTH times, fix up signs, pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= OP_MUL;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
      r_div0   <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op   <= w_op;
            r_neg1 <= w_neg1;
            r_neg2 <= w_neg2;
            r_div0 <= w_b_zero;
            r_cnt  <= CNT_W'(D_WIDTH - 1);
`ifdef MULDIV_EARLY_OUT_EN
            if (w_special) begin
              r_state  <= DONE;
              r_result <= w_special_val;
            end else begin
              r_state <= CALC;
            end
`else
            r_state <= CALC;
`endif
          end
        end
        CALC: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) r_state <= FIXUP;
          end
        end
        FIXUP: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_result <= w_fix;
            r_state  <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign stall  = (start & (r_state == IDLE) & ~flush) | (busy & ~done);
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table, multi-cycle corner sequences (flush,
// ignored start, reset mid-operation) and randomized operations against a
// plain-arithmetic RV32M reference model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] aluop1;
  logic [31:0] aluop2;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 13;
  vec_t tv[NV];

  muldiv_seq #(.D_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .aluop1 (aluop1),
    .aluop2 (aluop2),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (o)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == INT_MIN && b == 32'hFFFF_FFFF) r = INT_MIN;
        else r = 32'(sa / sb);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == INT_MIN && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Cycle of the done pulse, counting the accept cycle as 0.
  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = 34;
`ifdef MULDIV_EARLY_OUT_EN
    if (o[2] && b == 0) lat = 1;
    else if ((o == 3'd4 || o == 3'd6) && a == INT_MIN && b == 32'hFFFF_FFFF) lat = 1;
    else if (!o[2] && (a == 0 || b == 0)) lat = 1;
`endif
    return lat;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one cycle (cycle 0); returns 1 ns into cycle 1.
  task automatic start_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b);
    next_cycle();
    op = o; aluop1 = a; aluop2 = b; start = 1'b1;
    @(negedge clk);
    check({name, "_stall_c0"}, {31'b0, stall}, 32'd1);
    next_cycle();
    start  = 1'b0;
    aluop1 = $urandom;
    aluop2 = $urandom;
  endtask

  task automatic wait_done(input string name, input int lat, output logic [31:0] res);
    int k;
    bit seen;
    k = 1;
    seen = 1'b0;
    while (k <= 100 && !seen) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        next_cycle();
        k++;
      end
    end
    check({name, "_done_cycle"}, 32'(k), 32'(lat));
    res = result;
    if (seen) begin
      next_cycle();
      @(negedge clk);
      check({name, "_busy_after"}, {31'b0, busy}, 32'd0);
      check({name, "_done_1cyc"}, {31'b0, done}, 32'd0);
    end
  endtask

  task automatic run_and_check(input string name, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    start_op(name, o, a, b);
    wait_done(name, exp_lat(o, a, b), res);
    check({name, "_result"}, res, exp);
  endtask

  initial begin
    int dcount;
    int bcount;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  o;

    tv[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tv[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tv[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tv[3]  = '{3'd4, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFD};
    tv[4]  = '{3'd6, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFE};
    tv[5]  = '{3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF};
    tv[6]  = '{3'd7, 32'd100,       32'd0,         32'd100};
    tv[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tv[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    tv[9]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    tv[10] = '{3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
    tv[11] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    tv[12] = '{3'd5, 32'd1000,      32'd7,         32'd142};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; aluop1 = '0; aluop2 = '0;
    #2;
    check("rst_busy",   {31'b0, busy},  32'd0);
    check("rst_done",   {31'b0, done},  32'd0);
    check("rst_stall",  {31'b0, stall}, 32'd0);
    check("rst_result", result,         32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++)
      run_and_check($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].exp);

    // Flush in CALC, with an extra start pulse while busy that must be dropped.
    start_op("flush", 3'd5, 32'd5000, 32'd3);
    repeat (4) next_cycle();
    op = 3'd0; aluop1 = 32'd9; aluop2 = 32'd9; start = 1'b1;
    @(negedge clk);
    check("busy_start_stall", {31'b0, stall}, 32'd1);
    next_cycle();
    start = 1'b0;
    repeat (4) next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy_c11", {31'b0, busy}, 32'd0);
    dcount = 0;
    bcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
      if (busy) bcount++;
    end
    check("flush_no_done",   32'(dcount), 32'd0);
    check("flush_no_requeue", 32'(bcount), 32'd0);
    check("flush_result_held", result, tv[NV-1].exp);

    // Start together with flush in IDLE is not accepted.
    next_cycle();
    op = 3'd0; aluop1 = 32'd2; aluop2 = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("startflush_stall", {31'b0, stall}, 32'd0);
    next_cycle();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("startflush_busy", {31'b0, busy}, 32'd0);

    // Flush during DONE: done still pulses, result already written.
    start_op("flushdone", 3'd0, 32'd3, 32'd5);
    repeat (33) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flushdone_done",   {31'b0, done}, 32'd1);
    check("flushdone_result", result,        32'd15);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("flushdone_idle", {31'b0, busy}, 32'd0);

    // Asynchronous reset in cycle 20 of a multiply.
    start_op("rstmid", 3'd0, 32'h1234, 32'h10);
    repeat (19) next_cycle();
    #2 rst = 1'b1;
    #1;
    check("rstmid_busy",   {31'b0, busy}, 32'd0);
    check("rstmid_done",   {31'b0, done}, 32'd0);
    check("rstmid_result", result,        32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_and_check("post_rst", 3'd0, 32'd6, 32'd7, 32'd42);

    // Randomized operations, biased towards the special cases.
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = INT_MIN; b = 32'hFFFF_FFFF; end
        2: a = 32'd0;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_and_check($sformatf("rnd%0d", i), o, a, b, ref_model(o, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
